// File: rtl/branch_predictor_bht.sv
// Bimodal branch history table of 2-bit saturating counters with misprediction statistics.
// Define BHT_GSHARE_EN to XOR a non-speculative global history register into the index.
module branch_predictor_bht #(
  parameter int IDX_W = 6,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [PC_W-1:0]  pc_IF,
  input  logic             is_branch_IF,
  output logic             prediction_IF,
  output logic [IDX_W-1:0] pred_idx_IF,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic             upd_mispredict,
  output logic [CNT_W-1:0] mispredict_cnt,
  output logic [CNT_W-1:0] branch_cnt
);

  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  logic [1:0]       ctr [DEPTH];
  ctr_e             ctr_cur;
  ctr_e             ctr_next;
  logic [IDX_W-1:0] idx;

  // Word-aligned fetch: low two bits and bits above the index never select an entry.
  logic unused_pc;
  assign unused_pc = ^{pc_IF[PC_W-1:IDX_W+2], pc_IF[1:0]};

`ifdef BHT_GSHARE_EN
  logic [IDX_W-1:0] ghr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ghr <= '0;
    end else if (upd_valid) begin
      ghr <= {ghr[IDX_W-2:0], upd_taken};
    end
  end

  assign idx = pc_IF[IDX_W+1:2] ^ ghr;
`else
  assign idx = pc_IF[IDX_W+1:2];
`endif

  // Lookup reads the registered table, so a same-cycle update is seen only next cycle.
  assign pred_idx_IF   = idx;
  assign prediction_IF = is_branch_IF & ctr[idx][1];

  // NOTE: ctr_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    ctr_cur  = ctr_e'(ctr[upd_idx]);
    ctr_next = ctr_cur;
    case (ctr_cur)
      SNT:     ctr_next = upd_taken ? WNT : SNT;
      WNT:     ctr_next = upd_taken ? WT  : SNT;
      WT:      ctr_next = upd_taken ? ST  : WNT;
      ST:      ctr_next = upd_taken ? ST  : WT;
      default: ctr_next = WNT;
    endcase
  end

  // NOTE: the table is flops, not RAM, so every entry can take the weakly-not-taken reset value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr[i] <= WNT;
      end
    end else if (upd_valid) begin
      // NOTE: non-blocking so the lookup this cycle still sees the old counter value.
      ctr[upd_idx] <= ctr_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (upd_valid) begin
      if (branch_cnt != '1) begin
        branch_cnt <= branch_cnt + CNT_W'(1);
      end
      if (upd_mispredict && (mispredict_cnt != '1)) begin
        mispredict_cnt <= mispredict_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht: a reference model fills a scoreboard queue
// at each drive point and immediate assertions compare as the DUT responds.
module tb_branch_predictor_bht;

  localparam int IDX_W = 6;
  localparam int PC_W  = 32;
  localparam int CNT_W = 16;
  localparam int DEPTH = 1 << IDX_W;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [PC_W-1:0]  pc_IF = '0;
  logic             is_branch_IF = 1'b0;
  logic             prediction_IF;
  logic [IDX_W-1:0] pred_idx_IF;
  logic             upd_valid = 1'b0;
  logic [IDX_W-1:0] upd_idx = '0;
  logic             upd_taken = 1'b0;
  logic             upd_mispredict = 1'b0;
  logic [CNT_W-1:0] mispredict_cnt;
  logic [CNT_W-1:0] branch_cnt;

  branch_predictor_bht #(.IDX_W(IDX_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pc_IF          (pc_IF),
    .is_branch_IF   (is_branch_IF),
    .prediction_IF  (prediction_IF),
    .pred_idx_IF    (pred_idx_IF),
    .upd_valid      (upd_valid),
    .upd_idx        (upd_idx),
    .upd_taken      (upd_taken),
    .upd_mispredict (upd_mispredict),
    .mispredict_cnt (mispredict_cnt),
    .branch_cnt     (branch_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  string       tag_q [$];
  logic [31:0] exp_q [$];

  logic [1:0]       mtab [DEPTH];
  logic [IDX_W-1:0] mghr;
  logic [CNT_W-1:0] mbr;
  logic [CNT_W-1:0] mmis;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) mtab[i] = 2'd1;
    mghr = '0;
    mbr  = '0;
    mmis = '0;
  endfunction

  function automatic logic [IDX_W-1:0] midx(input logic [PC_W-1:0] pc);
`ifdef BHT_GSHARE_EN
    return pc[IDX_W+1:2] ^ mghr;
`else
    return pc[IDX_W+1:2];
`endif
  endfunction

  function automatic void model_update(input logic [IDX_W-1:0] ui, input logic ut, input logic um);
    if (ut && mtab[ui] != 2'd3) mtab[ui] = mtab[ui] + 2'd1;
    else if (!ut && mtab[ui] != 2'd0) mtab[ui] = mtab[ui] - 2'd1;
    mghr = {mghr[IDX_W-2:0], ut};
    if (mbr != {CNT_W{1'b1}}) mbr = mbr + 1'b1;
    if (um && mmis != {CNT_W{1'b1}}) mmis = mmis + 1'b1;
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] want;
    string       t;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $error("FAIL %s scoreboard empty observed=%0h", tag, obs);
      return;
    end
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", t, obs, want);
    end
  endtask

  task automatic const_check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    push(tag, want);
    check(tag, obs);
  endtask

  // One cycle: drive at negedge, compare outputs mid-cycle, advance the model at posedge.
  task automatic step(input logic [PC_W-1:0] pc, input logic br, input logic uv,
                      input logic [IDX_W-1:0] ui, input logic ut, input logic um,
                      input string tag, input int want_pred = -1);
    @(negedge clk);
    pc_IF = pc; is_branch_IF = br;
    upd_valid = uv; upd_idx = ui; upd_taken = ut; upd_mispredict = um;
    push({tag, "_pred"}, {31'b0, br & mtab[midx(pc)][1]});
    push({tag, "_idx"},  32'(midx(pc)));
    push({tag, "_bcnt"}, 32'(mbr));
    push({tag, "_mcnt"}, 32'(mmis));
`ifndef BHT_GSHARE_EN
    if (want_pred >= 0) push({tag, "_pred_const"}, 32'(want_pred));
`endif
    #1;
    check(tag, {31'b0, prediction_IF});
    check(tag, 32'(pred_idx_IF));
    check(tag, 32'(branch_cnt));
    check(tag, 32'(mispredict_cnt));
`ifndef BHT_GSHARE_EN
    if (want_pred >= 0) check(tag, {31'b0, prediction_IF});
`endif
    @(posedge clk);
    if (uv) model_update(ui, ut, um);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    upd_valid = 1'b0;
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    const_check("rst_bcnt", 32'(branch_cnt), 32'd0);
    const_check("rst_mcnt", 32'(mispredict_cnt), 32'd0);
    step(32'h40, 1'b1, 1'b0, '0, 1'b0, 1'b0, "rst_lookup", 0);

    // Training on the entry for pc 0x40 (idx 16 in the plain build).
    step(32'h40, 1'b1, 1'b1, midx(32'h40), 1'b1, 1'b0, "train_t1");
    step(32'h40, 1'b1, 1'b1, midx(32'h40), 1'b1, 1'b0, "train_t2");
    step(32'h40, 1'b1, 1'b0, '0, 1'b0, 1'b0, "train_after_tt", 1);
    step(32'h40, 1'b1, 1'b1, 6'd16, 1'b0, 1'b0, "train_nt1");
    step(32'h40, 1'b1, 1'b0, '0, 1'b0, 1'b0, "train_after_nt1", 1);
    step(32'h40, 1'b1, 1'b1, 6'd16, 1'b0, 1'b0, "train_nt2");
    step(32'h40, 1'b1, 1'b0, '0, 1'b0, 1'b0, "train_after_nt2", 0);

    // Saturation at ST and aliasing of pc 0x10C onto idx 3.
    for (int i = 0; i < 5; i++) step(32'h0C, 1'b0, 1'b1, 6'd3, 1'b1, 1'b0, "sat_taken");
    step(32'h0C, 1'b0, 1'b1, 6'd3, 1'b0, 1'b0, "sat_nt");
    step(32'h0C, 1'b1, 1'b0, '0, 1'b0, 1'b0, "sat_pc0c", 1);
    step(32'h10C, 1'b1, 1'b0, '0, 1'b0, 1'b0, "alias_pc10c", 1);
    step(32'h0C, 1'b0, 1'b0, '0, 1'b0, 1'b0, "not_branch", 0);

    // Same-cycle lookup and update of idx 5 (WNT): old value now, new value next cycle.
    step(32'h14, 1'b1, 1'b1, 6'd5, 1'b1, 1'b0, "conflict_same", 0);
    step(32'h14, 1'b1, 1'b0, '0, 1'b0, 1'b0, "conflict_next", 1);

    // Reset asserted mid-run with an update pending in the same cycle.
    @(negedge clk);
    upd_valid = 1'b1; upd_idx = 6'd16; upd_taken = 1'b1; upd_mispredict = 1'b1;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    const_check("midrst_bcnt", 32'(branch_cnt), 32'd0);
    @(posedge clk);
    @(negedge clk);
    upd_valid = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) step(32'(i * 4), 1'b1, 1'b0, '0, 1'b0, 1'b0, "rst_sweep", 0);
    #1;
    const_check("sweep_bcnt", 32'(branch_cnt), 32'd0);
    const_check("sweep_mcnt", 32'(mispredict_cnt), 32'd0);

    // Statistics: ten resolutions, four mispredicted.
    for (int i = 0; i < 10; i++)
      step(32'h80, 1'b1, 1'b1, 6'(i), i[0], (i == 1 || i == 4 || i == 6 || i == 9), "stats");
    @(negedge clk);
    upd_valid = 1'b0;
    #1;
    const_check("stats_bcnt", 32'(branch_cnt), 32'd10);
    const_check("stats_mcnt", 32'(mispredict_cnt), 32'd4);

    // Drive both counters into saturation, then one further update must not wrap.
    @(negedge clk);
    upd_valid = 1'b1; upd_idx = 6'd0; upd_taken = 1'b1; upd_mispredict = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      @(posedge clk);
      model_update(6'd0, 1'b1, 1'b1);
    end
    @(negedge clk);
    upd_valid = 1'b0;
    #1;
    const_check("satcnt_bcnt", 32'(branch_cnt), 32'h0000_FFFF);
    const_check("satcnt_mcnt", 32'(mispredict_cnt), 32'h0000_FFFF);
    step(32'h0, 1'b1, 1'b1, 6'd1, 1'b0, 1'b1, "satcnt_extra");
    @(negedge clk);
    upd_valid = 1'b0;
    #1;
    const_check("satcnt_hold_bcnt", 32'(branch_cnt), 32'h0000_FFFF);
    const_check("satcnt_hold_mcnt", 32'(mispredict_cnt), 32'h0000_FFFF);

    // Index hashing: three taken resolutions build history 6'b000111 when gshare is on.
    reset_pulse();
    for (int i = 0; i < 3; i++) step(32'h0, 1'b0, 1'b1, 6'd0, 1'b1, 1'b0, "hist");
    @(negedge clk);
    upd_valid = 1'b0; pc_IF = 32'h40; is_branch_IF = 1'b0;
    #1;
`ifdef BHT_GSHARE_EN
    const_check("gshare_idx", 32'(pred_idx_IF), 32'd23);
`else
    const_check("plain_idx", 32'(pred_idx_IF), 32'd16);
`endif
    const_check("hist_not_branch", {31'b0, prediction_IF}, 32'd0);
    step(32'h40, 1'b1, 1'b0, '0, 1'b0, 1'b0, "hist_lookup");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor_bht.md
Name: branch_predictor_bht

Overview:
- Fetch-side branch predictor feeding the issue-stage branch comparator.
- Holds a table of 2-bit saturating counters indexed by fetch PC bits.
- Produces the `prediction` bit and the table index that travel down the pipeline with the branch.
- Consumes the comparator's resolution (`branchTaken`, `falseTaken | falseNotTaken`) to train the counters and count mispredictions.

Parameters:
- IDX_W, 6: table index width; table depth = 2^IDX_W entries.
- PC_W, 32: program counter width.
- CNT_W, 16: misprediction statistics counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- pc_IF  in  PC_W  fetch-stage PC.
- is_branch_IF  in  1  fetched instruction is BEQ/BNE (pre-decode).
- prediction_IF  out  1  predicted taken; combinational.
- pred_idx_IF  out  IDX_W  table index used for this lookup; piped to the issue stage.
- upd_valid  in  1  a branch resolved in the issue stage this cycle.
- upd_idx  in  IDX_W  `pred_idx_IF` carried with the resolving branch.
- upd_taken  in  1  `branchTaken` from the comparator.
- upd_mispredict  in  1  `falseTaken | falseNotTaken` from the comparator.
- mispredict_cnt  out  CNT_W  saturating count of mispredicted branches.
- branch_cnt  out  CNT_W  saturating count of resolved branches.

Behaviour:
- Reset: asynchronous on reset_n low.
  - All counters reset to 2'b01 (weakly not-taken).
  - mispredict_cnt and branch_cnt reset to 0.
  - The history register (when compiled in) resets to 0.
  - The outputs depend only on this state, so after reset prediction_IF = 0 for every PC.
- Index:
  - Base: idx = pc_IF[IDX_W+1:2]. The PC is word aligned, so bits [1:0] are ignored.
  - pred_idx_IF = idx.
- Lookup:
  - prediction_IF = is_branch_IF & ctr[idx][1].
  - Lookup is zero-latency combinational, read from the registered table.
  - prediction_IF = 0 whenever is_branch_IF = 0.
- Counter FSM per entry, updated on the rising edge when upd_valid = 1:
  - States: SNT=00, WNT=01, WT=10, ST=11.
  - When upd_taken = 1: SNT→WNT, WNT→WT, WT→ST, ST→ST.
  - When upd_taken = 0: ST→WT, WT→WNT, WNT→SNT, SNT→SNT.
  - Only entry upd_idx changes; all other entries hold.
- Simultaneous lookup and update of the same index:
  - The lookup returns the pre-update value; there is no write-through bypass.
  - The update takes effect on the next cycle.
- Statistics: on upd_valid, branch_cnt increments by 1 and mispredict_cnt increments by upd_mispredict. Both counters saturate at all-ones and never wrap.
- Ignored inputs:
  - upd_taken and upd_mispredict are ignored when upd_valid = 0.
  - upd_mispredict is not used for training, only for statistics.
- Reset asserted mid-operation:
  - All state returns to reset values immediately.
  - An update pending in the same cycle is discarded.

Optional Feature:
- Macro: BHT_GSHARE_EN.
- With BHT_GSHARE_EN defined:
  - Adds an IDX_W-bit global history register ghr.
  - Index becomes idx = pc_IF[IDX_W+1:2] ^ ghr.
  - On upd_valid, ghr <= {ghr[IDX_W-2:0], upd_taken}; history is updated non-speculatively at resolution.
  - pred_idx_IF reflects the hashed index, so updates train the entry actually used for the lookup.
- Without BHT_GSHARE_EN:
  - No ghr register exists.
  - Index is the PC bits only.

Test Plan:
- Reset check: assert reset_n = 0 mid-run, release, sweep pc_IF 0x0..0xFC with is_branch_IF = 1 → prediction_IF = 0 everywhere, both counters read 0.
- Training: with pc_IF = 0x40, send two updates upd_valid=1, upd_idx=16, upd_taken=1 → prediction_IF = 1 for 0x40. Then one not-taken update → still 1 (WT). A second not-taken update → 0.
- Saturation and aliasing:
  - Five taken updates on idx 3, then one not-taken → prediction for pc 0x0C stays 1.
  - pc 0x10C (aliases to idx 3) → also predicts 1.
- Same-cycle conflict: ctr[5] = WNT, lookup pc 0x14 while updating idx 5 taken → prediction_IF = 0 this cycle, 1 the next cycle.
- Statistics:
  - 10 updates with upd_mispredict = 1 on 4 of them → branch_cnt = 10, mispredict_cnt = 4.
  - Force both counters to 0xFFFF, send one more update → both stay at 0xFFFF.
- Gshare (BHT_GSHARE_EN, IDX_W=6):
  - Three taken updates → ghr = 6'b000111.
  - pc 0x40 then yields pred_idx_IF = 16 ^ 7 = 23.
  - is_branch_IF = 0 → prediction_IF = 0.
